// File: rtl/approx_mult_err_sweep.sv
// Exhaustive error-characterisation harness for a combinational approximate WxW multiplier:
// sweeps every operand pair and accumulates count, max, sum and signed bias of the error.
//
// state | meaning
// IDLE  | waiting for start after reset
// SWEEP | presenting operand pairs, one per cycle; stage register filling
// DRAIN | last captured pair is being accumulated
// DONE  | results held, done high until the next start
module approx_mult_err_sweep #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [W-1:0]   num1,
  output logic [W-1:0]   num2,
  input  logic [2*W-1:0] w,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   err_count,
  output logic [2*W-1:0] max_ed,
  output logic [W-1:0]   worst_a,
  output logic [W-1:0]   worst_b,
  output logic [4*W-1:0] sum_ed,
  output logic [4*W:0]   sum_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  logic [2*W-1:0] r_cnt;
  logic [W-1:0]   r_stg_a;
  logic [W-1:0]   r_stg_b;
  logic [2*W-1:0] r_stg_p;
  logic           r_stg_v;
  logic           r_busy;
  logic           r_done;
  logic [2*W:0]   r_err_count;
  logic [2*W-1:0] r_max_ed;
  logic [W-1:0]   r_worst_a;
  logic [W-1:0]   r_worst_b;
  logic [4*W-1:0] r_sum_ed;
  logic [4*W:0]   r_sum_err;

  logic [2*W-1:0] w_exact;
  logic [2*W:0]   w_e;
  logic [2*W:0]   w_e_neg;
  logic [2*W-1:0] w_ed;
  logic [4*W:0]   w_e_ext;

  // Exact product and error are formed from the stage register, one cycle behind the operands.
  assign w_exact = {{W{1'b0}}, r_stg_a} * {{W{1'b0}}, r_stg_b};
  assign w_e     = {1'b0, r_stg_p} - {1'b0, w_exact};
  assign w_e_neg = -w_e;
  assign w_ed    = w_e[2*W] ? w_e_neg[2*W-1:0] : w_e[2*W-1:0];
  assign w_e_ext = {{(2*W){w_e[2*W]}}, w_e};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_stg_a     <= '0;
      r_stg_b     <= '0;
      r_stg_p     <= '0;
      r_stg_v     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_count <= '0;
      r_max_ed    <= '0;
      r_worst_a   <= '0;
      r_worst_b   <= '0;
      r_sum_ed    <= '0;
      r_sum_err   <= '0;
    end else begin
      // Strict compare keeps the earliest pair on ties.
      if (r_stg_v) begin
        r_err_count <= r_err_count + (2*W+1)'(w_e != '0);
        r_sum_ed    <= r_sum_ed + {{(2*W){1'b0}}, w_ed};
        r_sum_err   <= r_sum_err + w_e_ext;
        if (w_ed > r_max_ed) begin
          r_max_ed  <= w_ed;
          r_worst_a <= r_stg_a;
          r_worst_b <= r_stg_b;
        end
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_cnt       <= '0;
            r_err_count <= '0;
            r_max_ed    <= '0;
            r_worst_a   <= '0;
            r_worst_b   <= '0;
            r_sum_ed    <= '0;
            r_sum_err   <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_state     <= S_SWEEP;
          end
        end
        S_SWEEP: begin
          r_stg_a <= r_cnt[2*W-1:W];
          r_stg_b <= r_cnt[W-1:0];
          r_stg_p <= w;
          r_stg_v <= 1'b1;
          r_cnt   <= r_cnt + 1'b1;
          if (&r_cnt) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_stg_v <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign num1      = r_cnt[2*W-1:W];
  assign num2      = r_cnt[W-1:0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign err_count = r_err_count;
  assign max_ed    = r_max_ed;
  assign worst_a   = r_worst_a;
  assign worst_b   = r_worst_b;
  assign sum_ed    = r_sum_ed;
  assign sum_err   = r_sum_err;

endmodule

// File: tb/tb_approx_mult_err_sweep.sv
// Bench for approx_mult_err_sweep: table-driven multiplier stand-in, whole-sweep metrics
// recomputed by a plain arithmetic loop over all operand pairs.
module tb_approx_mult_err_sweep;
  localparam int TW = 4;
  localparam int NA = 1 << TW;
  localparam int NP = 1 << (2*TW);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [TW-1:0]   num1, num2;
  logic [2*TW-1:0] w;
  logic            busy, done;
  logic [2*TW:0]   err_count;
  logic [2*TW-1:0] max_ed;
  logic [TW-1:0]   worst_a, worst_b;
  logic [4*TW-1:0] sum_ed;
  logic [4*TW:0]   sum_err;

  logic [2*TW-1:0] w_tab [NP];

  int checks = 0;
  int errors = 0;

  longint m_cnt, m_max, m_wa, m_wb, m_sed, m_serr;

  approx_mult_err_sweep #(.W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num1(num1), .num2(num2), .w(w),
    .busy(busy), .done(done),
    .err_count(err_count), .max_ed(max_ed),
    .worst_a(worst_a), .worst_b(worst_b),
    .sum_ed(sum_ed), .sum_err(sum_err)
  );

  always #5 clk = ~clk;

  assign w = w_tab[{num1, num2}];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_exact();
    for (int a = 0; a < NA; a++)
      for (int b = 0; b < NA; b++)
        w_tab[a*NA + b] = (2*TW)'(a*b);
  endtask

  // Sweep order is a outer, b inner; strict > keeps the first pair reaching the max.
  task automatic build_ref();
    longint ex, ap, e, ed;
    m_cnt = 0; m_max = 0; m_wa = 0; m_wb = 0; m_sed = 0; m_serr = 0;
    for (int a = 0; a < NA; a++)
      for (int b = 0; b < NA; b++) begin
        ex = a*b;
        ap = longint'(w_tab[a*NA + b]);
        e  = ap - ex;
        ed = (e < 0) ? -e : e;
        if (e != 0) m_cnt++;
        m_sed  += ed;
        m_serr += e;
        if (ed > m_max) begin
          m_max = ed; m_wa = a; m_wb = b;
        end
      end
  endtask

  task automatic check_results(input string tag);
    longint se;
    se = $signed(sum_err);
    check({tag, " err_count"}, 64'(err_count), m_cnt);
    check({tag, " max_ed"},    64'(max_ed),    m_max);
    check({tag, " worst_a"},   64'(worst_a),   m_wa);
    check({tag, " worst_b"},   64'(worst_b),   m_wb);
    check({tag, " sum_ed"},    64'(sum_ed),    m_sed);
    check({tag, " sum_err"},   se,             m_serr);
  endtask

  // Called at a negedge; the next posedge is the start edge.
  task automatic do_sweep(input string tag, input bit jitter);
    int cnt;
    build_ref();
    start = 1'b1;
    @(negedge clk);
    cnt = 1;
    start = jitter ? 1'($urandom_range(0, 1)) : 1'b0;
    check({tag, " busy_early"}, 64'(busy), 1);
    check({tag, " done_early"}, 64'(done), 0);
    while (!done && cnt < NP + 10) begin
      @(negedge clk);
      cnt++;
      start = (jitter && cnt < NP - 4) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    check({tag, " done_edges"}, 64'(cnt), NP + 2);
    check({tag, " busy_end"}, 64'(busy), 0);
    check({tag, " num_wrap"}, 64'({num1, num2}), 0);
    check_results(tag);
    @(negedge clk);
    check({tag, " done_hold"}, 64'(done), 1);
    check({tag, " sum_ed_hold"}, 64'(sum_ed), m_sed);
  endtask

  initial begin
    int guard;
    fill_exact();
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 0);
    check("rst done", 64'(done), 0);
    check("rst num", 64'({num1, num2}), 0);
    check("rst err_count", 64'(err_count), 0);
    check("rst sum_err", 64'(sum_err), 0);
    rst_n = 1'b1;

    do_sweep("exact", 1'b0);

    for (int i = 0; i < NP; i++) w_tab[i] = '0;
    @(negedge clk);
    do_sweep("zero", 1'b0);
    check("zero sum_ed const", 64'(sum_ed), 14400);
    check("zero worst const", 64'({worst_a, worst_b}), 64'hFF);

    for (int i = 0; i < NP; i++) w_tab[i] = '1;
    @(negedge clk);
    do_sweep("ones", 1'b1);

    fill_exact();
    w_tab[3*NA + 5] = w_tab[3*NA + 5] + 1'b1;
    @(negedge clk);
    do_sweep("single", 1'b0);

    fill_exact();
    w_tab[10*NA + 10] = w_tab[10*NA + 10] + 8'd16;
    w_tab[12*NA + 1]  = w_tab[12*NA + 1] + 8'd16;
    @(negedge clk);
    do_sweep("tie", 1'b0);

    for (int a = 0; a < NA; a++)
      for (int b = 0; b < NA; b++)
        w_tab[a*NA + b] = (2*TW)'((a*b) | ((a & b) << 1));
    @(negedge clk);
    do_sweep("or_mult", 1'b1);
    check("or_mult bias sign", 64'(sum_err[4*TW]), 0);

    repeat (3) begin
      for (int i = 0; i < NP; i++) w_tab[i] = (2*TW)'($urandom);
      @(negedge clk);
      do_sweep("rand", 1'b1);
    end

    for (int a = 0; a < NA; a++)
      for (int b = 0; b < NA; b++) begin
        int v;
        v = a*b + $urandom_range(0, 6) - 3;
        if (v < 0) v = 0;
        if (v > NP - 1) v = NP - 1;
        w_tab[a*NA + b] = (2*TW)'(v);
      end
    @(negedge clk);
    do_sweep("perturb", 1'b0);

    fill_exact();
    @(negedge clk);
    start = 1'b1;
    guard = 0;
    while ({num1, num2} != (2*TW)'(100) && guard < NP + 10) begin
      @(negedge clk);
      guard++;
    end
    check("midrst reached", 64'({num1, num2}), 100);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 0);
    check("midrst done", 64'(done), 0);
    check("midrst num", 64'({num1, num2}), 0);
    check("midrst err_count", 64'(err_count), 0);
    check("midrst sum_ed", 64'(sum_ed), 0);
    check("midrst max_ed", 64'(max_ed), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_sweep("restart", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/approx_mult_err_sweep.md
Name: approx_mult_err_sweep

Overview:
- Sequential characterisation harness that sits on both sides of a combinational approximate 8x8 multiplier.
- Upstream, it drives the multiplier operands through every operand pair.
- Downstream, it consumes each approximate product, compares it against an internally computed exact product, and accumulates error metrics.
- Used in silicon/FPGA bring-up and in regression to produce error count, max error distance, summed error distance and signed bias for any multiplier variant.

Parameters:
- W, 8: operand width of the multiplier under test; legal range 2..8.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sweep; sampled only in IDLE or DONE
- num1  out  W  operand A to multiplier under test (registered)
- num2  out  W  operand B to multiplier under test (registered)
- w  in  2W  approximate product returned combinationally from the multiplier
- busy  out  1  high while a sweep is in progress
- done  out  1  high (level) in DONE until the next accepted start
- err_count  out  2W+1  number of pairs with w != num1*num2
- max_ed  out  2W  largest |exact - approx|
- worst_a  out  W  operand A of the first pair reaching max_ed
- worst_b  out  W  operand B of the first pair reaching max_ed
- sum_ed  out  4W  sum of |exact - approx| over all pairs
- sum_err  out  4W+1  signed (two's complement) sum of (approx - exact)

Behaviour:
- Reset (async, rst_n=0):
  - State becomes IDLE.
  - num1, num2, busy, done, all accumulators and the worst_* outputs are 0.
  - Stage register valid bit is 0.
  - Reset mid-sweep aborts immediately; no partial results are retained.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE/DONE, start=1: clear all accumulators, worst_a/b and the operand counter; done=0, busy=1; go to SWEEP.
  - SWEEP: operand counter {num1,num2} (num2 is the LSBs) is presented for one cycle per pair, starting at 0. At each edge, capture {num1, num2, w, valid=1} into the stage register, then increment the counter. When the presented value is all-ones, go to DRAIN.
  - DRAIN: stage register holds the last pair. The accumulate happens at this edge, then valid=0; go to DONE with busy=0, done=1.
  - DONE: outputs are held until the next start.
- start while busy is ignored.
- Pipeline: operand present (cycle n) -> stage register (edge n) -> accumulate (edge n+1).
  - The exact product is num1*num2 computed from the stage-register operands, full 2W bits.
- Per-pair arithmetic, with e = approx - exact (signed, 2W+1 bits) and ed = |e|:
  - err_count += (e != 0)
  - sum_ed += ed
  - sum_err += sign-extended e
  - If ed > max_ed strictly, update max_ed, worst_a and worst_b. Ties keep the earliest pair in sweep order.
- Widths are sized so there is no overflow: the total pair count is 2^2W, and the largest sum_ed is below 2^4W.
- Timing: from the start edge, done rises 2^(2W)+2 edges later (65538 for W=8).
- num1/num2 after the sweep: they wrap to 0 after the all-ones pair and stay at 0 in DRAIN/DONE.
- The approximate product is sampled combinationally in the same cycle its operands are presented. The multiplier must settle within one clock.

Test Plan:
- w driven by an exact model (num1*num2), start pulse -> done after 65538 edges; err_count=0, max_ed=0, worst=(0,0), sum_ed=0, sum_err=0.
- w tied 0 -> err_count=65025, max_ed=65025, worst_a=255, worst_b=255, sum_ed=1065369600, sum_err=-1065369600.
- w tied 16'hFFFF -> err_count=65536, max_ed=65535, worst=(0,0), sum_ed=3229532160, sum_err=+3229532160.
- w = exact+1 only for pair (3,5), else exact -> err_count=1, max_ed=1, worst=(3,5), sum_ed=1, sum_err=1.
- w = exact, except 16 overestimates on pairs (10,10) and (200,1) -> worst=(10,10) (earliest tie), err_count=2, sum_ed=32.
- Reset mid-sweep at pair 1000, with start held high throughout -> all outputs 0 at reset. Restart after reset gives results identical to the exact-model run. start pulses during SWEEP do not restart the sweep (done timing unchanged).
- Approximate multiplier integration: connect the compressor-based 8x8 multiplier -> record all metrics as golden values. Check that sum_err >= 0, since OR-based compressors only overestimate.
